// File: rtl/ll_req_arbiter.sv
// ll_req_arbiter
// Round-robin front end that shares the single linked-list engine request
// port between NUM_REQ requesters. One request is in flight at a time. The
// arbiter waits for engine completion or a watchdog expiry before it grants
// again, and returns a one-cycle done or timeout pulse to the owner. A
// requester can hold a lock to run an uninterrupted sequence of operations.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. Valid, once raised by the arbiter (eng_req_vld), stays high with
//   stable fields until the matching ready is seen. Ready (rq_rdy) is a
//   combinational one-hot grant: it never depends on itself and is low
//   outside IDLE and while reset_n is low.

module ll_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_WD   = 3,
  parameter int SPEC_WD = 3,
  parameter int LL_WD   = 2,
  parameter int POS_WD  = 4,
  parameter int DATA_WD = 8,
  parameter int TMO_CYC = 255,
  localparam int IDX_WD = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // requester side
  input  logic [NUM_REQ-1:0]         rq_vld,
  input  logic [NUM_REQ-1:0]         rq_lock,
  input  logic [NUM_REQ*OP_WD-1:0]   rq_op,
  input  logic [NUM_REQ*SPEC_WD-1:0] rq_spec,
  input  logic [NUM_REQ*LL_WD-1:0]   rq_ll,
  input  logic [NUM_REQ*POS_WD-1:0]  rq_pos,
  input  logic [NUM_REQ*DATA_WD-1:0] rq_data,
  output logic [NUM_REQ-1:0]         rq_rdy,
  output logic [NUM_REQ-1:0]         rq_done,
  output logic [NUM_REQ-1:0]         rq_timeout,
  // engine side
  output logic                       eng_req_vld,
  output logic [OP_WD-1:0]           eng_op,
  output logic [SPEC_WD-1:0]         eng_spec,
  output logic [LL_WD-1:0]           eng_ll,
  output logic [POS_WD-1:0]          eng_pos,
  output logic [DATA_WD-1:0]         eng_data,
  input  logic                       eng_intf_ready,
  input  logic                       eng_resp_cmpltd,
  // status
  output logic                       busy,
  output logic [IDX_WD-1:0]          owner,
  output logic [7:0]                 tmo_err_cnt,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Last WAIT_CMPL count value before the watchdog fires.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t              state;
  logic [IDX_WD-1:0]   rr_ptr;
  logic                lock_actv;
  logic [IDX_WD-1:0]   lock_id;
  logic [7:0]          tmo_cnt;

  logic [NUM_REQ-1:0]  lock_mask;
  logic [NUM_REQ-1:0]  elig;
  logic                win_found;
  logic [IDX_WD-1:0]   win_idx;
  logic [IDX_WD-1:0]   cand_idx;
  int                  cand;
  logic                xfer;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Restrict eligibility to the lock holder while a lock is active.
  always_comb begin
    lock_mask          = '0;
    lock_mask[lock_id] = 1'b1;
    elig               = lock_actv ? (rq_vld & lock_mask) : rq_vld;
  end

  // Round-robin search starting one past the last grant, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = IDX_WD'(cand);
      if (!win_found && elig[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // One-hot grant, only in IDLE and never while reset is asserted.
  always_comb begin
    rq_rdy = '0;
    if (reset_n && (state == S_IDLE) && win_found) begin
      rq_rdy[win_idx] = 1'b1;
    end
  end

  assign xfer = |rq_rdy;

  // Main sequencer: accept, issue to the engine, then wait for completion or watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rr_ptr      <= IDX_WD'(NUM_REQ - 1);
      lock_actv   <= 1'b0;
      lock_id     <= '0;
      tmo_cnt     <= '0;
      tmo_err_cnt <= '0;
      owner       <= '0;
      eng_req_vld <= 1'b0;
      eng_op      <= '0;
      eng_spec    <= '0;
      eng_ll      <= '0;
      eng_pos     <= '0;
      eng_data    <= '0;
      rq_done     <= '0;
      rq_timeout  <= '0;
    end else begin
      rq_done    <= '0;
      rq_timeout <= '0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            eng_req_vld <= 1'b1;
            eng_op      <= rq_op[int'(win_idx)*OP_WD +: OP_WD];
            eng_spec    <= rq_spec[int'(win_idx)*SPEC_WD +: SPEC_WD];
            eng_ll      <= rq_ll[int'(win_idx)*LL_WD +: LL_WD];
            eng_pos     <= rq_pos[int'(win_idx)*POS_WD +: POS_WD];
            eng_data    <= rq_data[int'(win_idx)*DATA_WD +: DATA_WD];
            owner       <= win_idx;
            rr_ptr      <= win_idx;
            lock_actv   <= rq_lock[win_idx];
            lock_id     <= win_idx;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Completion strobes are meaningless before the engine accepted the request.
          if (eng_intf_ready) begin
            eng_req_vld <= 1'b0;
            tmo_cnt     <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion wins over a watchdog expiry in the same cycle.
          if (eng_resp_cmpltd) begin
            rq_done[owner] <= 1'b1;
            state          <= S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            rq_timeout[owner] <= 1'b1;
            if (tmo_err_cnt != 8'hFF) begin
              tmo_err_cnt <= tmo_err_cnt + 8'd1;
            end
            lock_actv <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: begin
          state       <= S_IDLE;
          eng_req_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Directed bench for ll_req_arbiter (NUM_REQ=4, TMO_CYC=10).
module tb_ll_req_arbiter;

  localparam int NR = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   rq_vld, rq_lock, rq_rdy, rq_done, rq_timeout;
  logic [NR*3-1:0] rq_op, rq_spec;
  logic [NR*2-1:0] rq_ll;
  logic [NR*4-1:0] rq_pos;
  logic [NR*8-1:0] rq_data;
  logic            eng_req_vld, eng_intf_ready, eng_resp_cmpltd, busy;
  logic [2:0]      eng_op, eng_spec;
  logic [1:0]      eng_ll, owner, state_dbg;
  logic [3:0]      eng_pos;
  logic [7:0]      eng_data, tmo_err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  ll_req_arbiter #(
    .NUM_REQ(NR), .OP_WD(3), .SPEC_WD(3), .LL_WD(2), .POS_WD(4),
    .DATA_WD(8), .TMO_CYC(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rq_vld(rq_vld), .rq_lock(rq_lock),
    .rq_op(rq_op), .rq_spec(rq_spec), .rq_ll(rq_ll), .rq_pos(rq_pos), .rq_data(rq_data),
    .rq_rdy(rq_rdy), .rq_done(rq_done), .rq_timeout(rq_timeout),
    .eng_req_vld(eng_req_vld), .eng_op(eng_op), .eng_spec(eng_spec), .eng_ll(eng_ll),
    .eng_pos(eng_pos), .eng_data(eng_data),
    .eng_intf_ready(eng_intf_ready), .eng_resp_cmpltd(eng_resp_cmpltd),
    .busy(busy), .owner(owner), .tmo_err_cnt(tmo_err_cnt), .state_dbg(state_dbg)
  );

  // scoreboard-style comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int idx, input logic [2:0] op, input logic [2:0] spec,
                            input logic [1:0] ll, input logic [3:0] pos, input logic [7:0] data);
    rq_op[idx*3 +: 3]   = op;
    rq_spec[idx*3 +: 3] = spec;
    rq_ll[idx*2 +: 2]   = ll;
    rq_pos[idx*4 +: 4]  = pos;
    rq_data[idx*8 +: 8] = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    rq_vld = '0; rq_lock = '0; rq_op = '0; rq_spec = '0; rq_ll = '0;
    rq_pos = '0; rq_data = '0; eng_intf_ready = 1'b0; eng_resp_cmpltd = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_rdy", 32'(rq_rdy), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_vld", 32'(eng_req_vld), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_errcnt", 32'(tmo_err_cnt), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    chk("rst_done", 32'(rq_done), 32'h0);
    reset_n = 1'b1;
    tick();

    // ---------------- single request ----------------
    set_fields(2, 3'd3, 3'd5, 2'd1, 4'd2, 8'hA5);
    rq_vld = 4'b0100; eng_intf_ready = 1'b1;
    #1;
    chk("single_rdy_T0", 32'(rq_rdy), 32'h4);
    tick();                                   // T1
    rq_vld = '0;
    chk("single_vld_T1", 32'(eng_req_vld), 32'h1);
    chk("single_op", 32'(eng_op), 32'h3);
    chk("single_spec", 32'(eng_spec), 32'h5);
    chk("single_ll", 32'(eng_ll), 32'h1);
    chk("single_pos", 32'(eng_pos), 32'h2);
    chk("single_data", 32'(eng_data), 32'hA5);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    tick();                                   // T2 (WAIT)
    chk("single_vld_T2", 32'(eng_req_vld), 32'h0);
    for (int t = 2; t < 6; t++) begin
      chk("single_nodone", 32'(rq_done), 32'h0);
      tick();
    end
    eng_resp_cmpltd = 1'b1;                   // T6 = issue + 5
    #1;
    chk("single_nodone_T6", 32'(rq_done), 32'h0);
    tick();                                   // T7
    eng_resp_cmpltd = 1'b0;
    chk("single_done", 32'(rq_done), 32'h4);
    chk("single_busy_after", 32'(busy), 32'h0);
    tick();
    chk("single_done_pulse", 32'(rq_done), 32'h0);

    // ---------------- round robin ----------------
    do_reset();
    rq_vld = 4'hF; eng_intf_ready = 1'b1; eng_resp_cmpltd = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 32'(rq_rdy), 32'(1 << (g % 4)));
      if (g > 0) chk("rr_done", 32'(rq_done), 32'(1 << ((g - 1) % 4)));
      tick();
      chk("rr_rdy_issue", 32'(rq_rdy), 32'h0);
      tick();
      chk("rr_rdy_wait", 32'(rq_rdy), 32'h0);
      tick();
    end
    rq_vld = '0; eng_resp_cmpltd = 1'b0;
    #1;
    chk("rr_last_done", 32'(rq_done), 32'h1);
    tick();

    // ---------------- engine backpressure ----------------
    set_fields(1, 3'd5, 3'd2, 2'd3, 4'd9, 8'h3C);
    rq_vld = 4'b0010; eng_intf_ready = 1'b0;
    #1;
    chk("bp_rdy", 32'(rq_rdy), 32'h2);
    tick();                                   // T1
    rq_vld = '0;
    for (int c = 1; c <= 8; c++) begin
      eng_resp_cmpltd = (c == 3);
      eng_intf_ready  = (c == 8);
      chk("bp_vld_hold", 32'(eng_req_vld), 32'h1);
      chk("bp_data_hold", 32'(eng_data), 32'h3C);
      chk("bp_pos_hold", 32'(eng_pos), 32'h9);
      chk("bp_op_hold", 32'(eng_op), 32'h5);
      chk("bp_nodone", 32'(rq_done), 32'h0);
      tick();
    end
    eng_intf_ready = 1'b0; eng_resp_cmpltd = 1'b1;   // first WAIT cycle
    chk("bp_vld_drop", 32'(eng_req_vld), 32'h0);
    chk("bp_nodone_wait", 32'(rq_done), 32'h0);
    chk("bp_busy_wait", 32'(busy), 32'h1);
    tick();
    eng_resp_cmpltd = 1'b0;
    chk("bp_done", 32'(rq_done), 32'h2);
    chk("bp_idle", 32'(busy), 32'h0);

    // ---------------- lock ----------------
    rq_vld = 4'b0101; eng_intf_ready = 1'b1; eng_resp_cmpltd = 1'b1;
    for (int g = 0; g < 3; g++) begin
      rq_lock = (g < 2) ? 4'b0100 : 4'b0000;
      rq_data[2*8 +: 8] = 8'(8'h20 + g);
      #1;
      chk("lock_grant2", 32'(rq_rdy), 32'h4);
      tick();
      chk("lock_data", 32'(eng_data), 32'(8'h20 + g));
      tick();
      tick();
    end
    rq_vld = 4'b0001;
    #1;
    chk("lock_grant0", 32'(rq_rdy), 32'h1);
    tick();
    rq_vld = '0;
    chk("lock_owner0", 32'(owner), 32'h0);
    tick();
    tick();
    chk("lock_done0", 32'(rq_done), 32'h1);
    eng_resp_cmpltd = 1'b0;

    // ---------------- watchdog ----------------
    rq_vld = 4'b1000; rq_lock = 4'b1000;
    #1;
    chk("wd_rdy", 32'(rq_rdy), 32'h8);
    tick();                                   // ISSUE, handshake
    rq_vld = '0; rq_lock = '0;
    tick();                                   // first WAIT cycle
    for (int k = 1; k <= 10; k++) begin
      chk("wd_no_tmo", 32'(rq_timeout), 32'h0);
      chk("wd_busy", 32'(busy), 32'h1);
      tick();
    end
    chk("wd_tmo", 32'(rq_timeout), 32'h8);
    chk("wd_errcnt", 32'(tmo_err_cnt), 32'h1);
    chk("wd_no_done", 32'(rq_done), 32'h0);
    chk("wd_idle", 32'(busy), 32'h0);
    rq_vld = 4'b0001;
    #1;
    chk("wd_lock_cleared", 32'(rq_rdy), 32'h1);
    tick();
    rq_vld = '0;
    tick();                                   // first WAIT cycle
    for (int k = 1; k <= 10; k++) begin
      eng_resp_cmpltd = (k == 10);
      chk("wd2_no_tmo", 32'(rq_timeout), 32'h0);
      chk("wd2_no_done", 32'(rq_done), 32'h0);
      tick();
    end
    eng_resp_cmpltd = 1'b0;
    chk("wd2_done", 32'(rq_done), 32'h1);
    chk("wd2_tmo", 32'(rq_timeout), 32'h0);
    chk("wd2_errcnt", 32'(tmo_err_cnt), 32'h1);
    tick();
    chk("wd2_quiet_tmo", 32'(rq_timeout), 32'h0);

    // ---------------- locked owner drops valid: stall ----------------
    rq_vld = 4'b0010; rq_lock = 4'b0010; eng_resp_cmpltd = 1'b1;
    #1;
    chk("stall_grant1", 32'(rq_rdy), 32'h2);
    tick();
    rq_vld = '0; rq_lock = '0;
    tick();
    tick();
    chk("stall_done1", 32'(rq_done), 32'h2);
    rq_vld = 4'b0001;
    #1;
    chk("stall_rdy0", 32'(rq_rdy), 32'h0);
    tick();
    chk("stall_rdy1", 32'(rq_rdy), 32'h0);
    chk("stall_idle", 32'(busy), 32'h0);
    rq_vld = 4'b0011;
    set_fields(1, 3'd6, 3'd1, 2'd2, 4'd7, 8'h5A);
    #1;
    chk("stall_resume", 32'(rq_rdy), 32'h2);
    tick();                                   // ISSUE
    rq_vld = '0; eng_resp_cmpltd = 1'b0;
    tick();                                   // WAIT 1
    tick();                                   // WAIT 2

    // ---------------- async reset mid-WAIT ----------------
    chk("ar_pre_owner", 32'(owner), 32'h1);
    chk("ar_pre_data", 32'(eng_data), 32'h5A);
    chk("ar_pre_busy", 32'(busy), 32'h1);
    rq_vld = 4'hF;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_owner", 32'(owner), 32'h0);
    chk("ar_data", 32'(eng_data), 32'h0);
    chk("ar_op", 32'(eng_op), 32'h0);
    chk("ar_errcnt", 32'(tmo_err_cnt), 32'h0);
    chk("ar_rdy", 32'(rq_rdy), 32'h0);
    chk("ar_state", 32'(state_dbg), 32'h0);
    tick();
    chk("ar_no_done", 32'(rq_done), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("ar_first_grant", 32'(rq_rdy), 32'h1);
    tick();
    rq_vld = '0;
    chk("ar_owner_after", 32'(owner), 32'h0);
    chk("ar_vld_after", 32'(eng_req_vld), 32'h1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
